// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master round-robin arbiter.
package spi_arb_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: the first set request found
// when scanning upward (with wrap) from rr_ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_req
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    gnt_idx  = '0;
    any_req  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        gnt_idx = cand_idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between NUM_REQ requesters: round-robin grant,
// start/busy handshake sequencing with watchdog, and ss_n routing.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [SPI_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [SPI_BYTE_W-1:0]         resp_data,
  output logic                          resp_err,
  output logic                          master_start,
  output logic [SPI_BYTE_W-1:0]         master_data_in,
  input  logic                          master_busy,
  input  logic [SPI_BYTE_W-1:0]         master_data_out,
  input  logic                          master_ss_n,
  output logic [NUM_REQ-1:0]            ss_n
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      start_q, start_d;
  logic [SPI_BYTE_W-1:0]     tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0]        ack_q, ack_d;
  logic [NUM_REQ-1:0]        rvalid_q, rvalid_d;
  logic [SPI_BYTE_W-1:0]     rdata_q, rdata_d;
  logic                      rerr_q, rerr_d;

  logic [IDX_W-1:0]          win_idx;
  logic                      win_any;
  logic                      timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt_idx (win_idx),
    .any_req (win_any)
  );

  // The watchdog fires on the cycle whose increment would reach TIMEOUT_CYC.
  assign timeout_hit = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    ack_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    rerr_d      = 1'b0;

    // Registered outputs are computed one cycle early, from the transition.
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          grant_idx_d    = win_idx;
          tx_byte_d      = req_data[{win_idx, 3'b000} +: SPI_BYTE_W];
          start_d        = 1'b1;
          ack_d[win_idx] = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_d = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (state_q == WAIT_BUSY && master_busy) begin
          state_d = WAIT_DONE;
        end else if (state_q == WAIT_DONE && !master_busy) begin
          rdata_d               = master_data_out;
          rvalid_d[grant_idx_q] = 1'b1;
          state_d               = RESP;
        end else if (timeout_hit) begin
          rdata_d               = '0;
          rerr_d                = 1'b1;
          rvalid_d[grant_idx_q] = 1'b1;
          state_d               = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      tx_byte_q   <= '0;
      ack_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      tx_byte_q   <= tx_byte_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
    end
  end

  // Only the granted slave follows the master's select; all others stay high.
  always_comb begin
    ss_n = '1;
    if (state_q != IDLE) ss_n[grant_idx_q] = master_ss_n;
  end

  assign req_ack        = ack_q;
  assign resp_valid     = rvalid_q;
  assign resp_data      = rdata_q;
  assign resp_err       = rerr_q;
  assign master_start   = start_q;
  assign master_data_in = tx_byte_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural spi_master stand-in.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ack, resp_valid, ss_n;
  logic [7:0]  resp_data, master_data_in;
  logic        resp_err, master_start;

  // Master model state
  logic        m_busy = 1'b0;
  logic        m_ss   = 1'b1;
  logic [7:0]  m_dout = '0;
  logic [7:0]  m_tx   = '0;
  logic [7:0]  miso_byte = '0;
  logic        start_prev = 1'b0;
  bit          stuck = 1'b0;
  int          m_cnt = 0;
  int          viol  = 0;
  int          cyc   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  spi_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_err        (resp_err),
    .master_start    (master_start),
    .master_data_in  (master_data_in),
    .master_busy     (m_busy),
    .master_data_out (m_dout),
    .master_ss_n     (m_ss),
    .ss_n            (ss_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Busy for 32 clocks after an accepted start, then returns miso_byte.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ss   <= 1'b1;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 31) begin
        m_busy <= 1'b0;
        m_ss   <= 1'b1;
        m_dout <= miso_byte;
      end
      m_cnt <= m_cnt + 1;
    end else if (master_start && !stuck) begin
      m_busy <= 1'b1;
      m_ss   <= 1'b0;
      m_cnt  <= 0;
      m_tx   <= master_data_in;
    end
    if (master_start && (m_busy || start_prev)) viol <= viol + 1;
    start_prev <= master_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] ack, output int t);
    ack = '0;
    t   = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (req_ack != 4'b0000) begin
        ack = req_ack;
        t   = cyc;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int budget, input logic [3:0] exp_ss,
                           output logic [3:0] rv, output int t, output int ss_bad);
    rv     = '0;
    t      = -1;
    ss_bad = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_busy && ss_n !== exp_ss) ss_bad++;
      if (resp_valid != 4'b0000) begin
        rv = resp_valid;
        t  = cyc;
        break;
      end
    end
  endtask

  logic [3:0] ack, rv;
  logic [7:0] bytes [4];
  int t_ack, t_resp, t_prev_resp, ss_bad, pulses;

  initial begin
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;

    // Reset values
    repeat (3) tick();
    check("rst_start",   master_start,   1'b0);
    check("rst_data_in", master_data_in, 8'h00);
    check("rst_ack",     req_ack,        4'h0);
    check("rst_rvalid",  resp_valid,     4'h0);
    check("rst_rdata",   resp_data,      8'h00);
    check("rst_rerr",    resp_err,       1'b0);
    check("rst_ss_n",    ss_n,           4'hF);
    rst = 1'b0;
    tick();

    // All four requesting continuously: grants 0,1,2,3,0
    req_valid = 4'b1111;
    req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};
    t_prev_resp = -1;
    for (int g = 0; g < 5; g++) begin
      wait_ack(10, ack, t_ack);
      check($sformatf("rr_ack%0d", g), ack, 4'b0001 << (g % 4));
      check($sformatf("rr_start%0d", g), master_start, 1'b1);
      check($sformatf("rr_txbyte%0d", g), master_data_in, bytes[g % 4]);
      if (g > 0) check($sformatf("rr_gap%0d", g), t_ack - t_prev_resp, 2);
      if (g == 4) req_valid = 4'b0000;
      miso_byte = 8'hC0 + 8'(g);
      wait_resp(100, ~(4'b0001 << (g % 4)), rv, t_resp, ss_bad);
      check($sformatf("rr_resp%0d", g), rv, 4'b0001 << (g % 4));
      check($sformatf("rr_rdata%0d", g), resp_data, 8'hC0 + 8'(g));
      check($sformatf("rr_ss%0d", g), ss_bad, 0);
      t_prev_resp = t_resp;
    end
    tick();

    // Single request from requester 1
    req_data  = 32'h0000_A500;
    req_valid = 4'b0010;
    miso_byte = 8'h3C;
    wait_ack(10, ack, t_ack);
    check("one_ack", ack, 4'b0010);
    check("one_txbyte", master_data_in, 8'hA5);
    req_valid = 4'b0000;
    tick();
    check("one_ack_pulse", req_ack, 4'b0000);
    wait_resp(100, 4'b1101, rv, t_resp, ss_bad);
    check("one_resp", rv, 4'b0010);
    check("one_rdata", resp_data, 8'h3C);
    check("one_rerr", resp_err, 1'b0);
    check("one_ss", ss_bad, 0);
    check("one_mosi", m_tx, 8'hA5);
    tick();
    check("one_resp_pulse", resp_valid, 4'b0000);

    // Fairness: serve 2, then 2 and 3 together -> 3 first
    req_data  = 32'h7700_6600;
    req_data[23:16] = 8'h66;
    req_valid = 4'b0100;
    wait_ack(10, ack, t_ack);
    check("fair_first", ack, 4'b0100);
    req_valid = 4'b0000;
    wait_resp(100, 4'b1011, rv, t_resp, ss_bad);
    req_valid = 4'b1100;
    wait_ack(10, ack, t_ack);
    check("fair_three", ack, 4'b1000);
    check("fair_three_byte", master_data_in, 8'h77);
    req_valid = 4'b0100;
    wait_resp(100, 4'b0111, rv, t_resp, ss_bad);
    wait_ack(10, ack, t_ack);
    check("fair_two", ack, 4'b0100);
    req_valid = 4'b0000;
    wait_resp(100, 4'b1011, rv, t_resp, ss_bad);
    check("fair_two_resp", rv, 4'b0100);
    tick();

    // Watchdog: master never goes busy
    stuck     = 1'b1;
    req_data  = 32'h0000_005A;
    req_valid = 4'b0001;
    wait_ack(10, ack, t_ack);
    check("wd_ack", ack, 4'b0001);
    req_valid = 4'b0000;
    wait_resp(200, 4'b1110, rv, t_resp, ss_bad);
    check("wd_resp", rv, 4'b0001);
    check("wd_rerr", resp_err, 1'b1);
    check("wd_rdata", resp_data, 8'h00);
    check("wd_latency", t_resp - (t_ack + 1), 64);
    stuck = 1'b0;
    tick();
    check("wd_err_pulse", resp_err, 1'b0);

    // Next request after the watchdog is served normally
    miso_byte = 8'hE7;
    req_valid = 4'b0001;
    wait_ack(10, ack, t_ack);
    check("post_wd_ack", ack, 4'b0001);
    req_valid = 4'b0000;
    wait_resp(100, 4'b1110, rv, t_resp, ss_bad);
    check("post_wd_resp", rv, 4'b0001);
    check("post_wd_rdata", resp_data, 8'hE7);
    check("post_wd_rerr", resp_err, 1'b0);
    tick();

    // Reset during WAIT_DONE
    miso_byte = 8'h99;
    req_data  = 32'h0000_00B4;
    req_valid = 4'b0001;
    wait_ack(10, ack, t_ack);
    req_valid = 4'b0000;
    repeat (8) tick();
    check("mid_busy", m_busy, 1'b1);
    check("mid_ss_active", ss_n, 4'b1110);
    rst = 1'b1;
    tick();
    check("mid_start",   master_start,   1'b0);
    check("mid_data_in", master_data_in, 8'h00);
    check("mid_ack",     req_ack,        4'h0);
    check("mid_rvalid",  resp_valid,     4'h0);
    check("mid_rdata",   resp_data,      8'h00);
    check("mid_rerr",    resp_err,       1'b0);
    check("mid_ss_n",    ss_n,           4'hF);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (resp_valid != 4'b0000 || req_ack != 4'b0000) pulses++;
    end
    check("mid_no_resp", pulses, 0);

    check("start_protocol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin scheduler that shares one `spi_master` between `NUM_REQ` requesters, each addressing its own slave. It accepts byte-transfer requests, sequences the master's start/busy handshake, and routes the master's `ss_n` to the granted slave. It returns the received byte and a timeout error flag to the requester. It sits between the register/control clients and the `spi_master` instance.

## Interface
- `NUM_REQ`, default 4: number of requesters and slave selects, legal range 2..8.
- `TIMEOUT_CYC`, default 64: watchdog limit, in `clk` cycles, for the master handshake.

Ports:
- `clk`  in  1  system clock; same clock as `spi_master`.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester transfer request (level).
- `req_data`  in  8*NUM_REQ  TX byte; requester i uses `[8*i+7:8*i]`.
- `req_ack`  out  NUM_REQ  one-cycle pulse when requester i's byte has been taken.
- `resp_valid`  out  NUM_REQ  one-cycle pulse when requester i's transfer has completed.
- `resp_data`  out  8  shared RX byte; valid only while some `resp_valid` bit is high.
- `resp_err`  out  1  qualifies `resp_valid`; 1 means the watchdog expired.
- `master_start`  out  1  connects to `spi_master.master_start`.
- `master_data_in`  out  8  connects to `spi_master.master_data_in`.
- `master_busy`  in  1  from `spi_master`.
- `master_data_out`  in  8  from `spi_master`.
- `master_ss_n`  in  1  from `spi_master.ss_n`.
- `ss_n`  out  NUM_REQ  per-slave select, active low.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- **IDLE:** if any `req_valid` is set, the round-robin winner is chosen, starting the search at `rr_ptr`. The arbiter registers `grant_idx` and the winner's byte, then moves to ISSUE. With no request it stays in IDLE.
- **ISSUE (one cycle):**
  - `master_start`=1 and `master_data_in` = the captured byte.
  - `req_ack[grant_idx]`=1.
  - `rr_ptr` <= (grant_idx+1) mod NUM_REQ.
  - Next state is WAIT_BUSY.
- **WAIT_BUSY:** waits for `master_busy`=1, then moves to WAIT_DONE.
- **WAIT_DONE:** waits for `master_busy`=0, latches `master_data_out` into `resp_data`, then moves to RESP.
- **RESP (one cycle):** `resp_valid[grant_idx]`=1, then back to IDLE.
- **Watchdog:**
  - A counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYC, the FSM goes to RESP with `resp_err`=1 and `resp_data`=8'h00.
  - Counter width is $clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- **Slave select routing (combinational):**
  - `ss_n[i]` = `master_ss_n` when i==grant_idx and the state is not IDLE; otherwise 1.
  - Outside IDLE, non-granted slaves are always 1.
- **Request handling:**
  - `req_valid` dropping after grant does not abort the transfer.
  - A requester that holds `req_valid` after `req_ack` is treated as making a new request.
  - Requests arriving outside IDLE wait; no requests are lost or queued beyond one per requester.
- **Fairness:** a requester that was just served has lowest priority in the next arbitration.
- **Reset values:**
  - state IDLE, `rr_ptr`=0, `grant_idx`=0.
  - `master_start`=0, `master_data_in`=0.
  - `req_ack`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0.
  - `ss_n` all 1.
- **Reset mid-transfer:** the arbiter returns to IDLE with no response pulse. The master must be reset from the same system reset, or ends its transfer on its own.

## Timing
- All outputs are registered except `ss_n`.
- **Request to start:** `req_valid` seen at edge T → `master_start` high for cycle T+1 → `master_busy` high by edge T+2.
- **Completion to response:** `master_busy` falls at edge D → `resp_valid` high during cycle D+1 with the final byte.
- **One 8-bit SPI transfer:** about 32 `clk` cycles. Request to `resp_valid` is about 36 cycles. Back-to-back transfers have a minimum gap of 1 IDLE cycle between `resp_valid` and the next `master_start`.
- **Constraints:** `master_start` is never high for more than 1 cycle, and never while `master_busy`=1. `req_ack` and `resp_valid` are each one-hot or zero.

## Structure
- Package `spi_arb_pkg` holds:
  - `arb_state_t` enum: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
  - constants `SPI_BYTE_W`=8, `DEF_NUM_REQ`=4, `DEF_TIMEOUT_CYC`=64.
- Sub-module `rr_arbiter`: combinational winner select from a `req` vector and `rr_ptr`. It outputs `gnt_idx` and `any_req`, and is reusable elsewhere.
- The top level contains the FSM, byte/grant registers, watchdog, and `ss_n` mux.

## Test plan
- **Single request:** `req_valid`=4'b0010 with byte 8'hA5, slave model returning 8'h3C → one `req_ack[1]` pulse, `ss_n`=4'b1101 for the whole transfer, MOSI bits 10100101, then `resp_valid[1]` with `resp_data`=8'h3C and `resp_err`=0.
- **All four requesting continuously:** `req_valid`=4'b1111 → grants in order 0,1,2,3,0 with a one-cycle IDLE gap each time; `master_start` never coincides with busy.
- **Fairness:** requester 2 served, then requests 2 and 3 asserted together → 3 is granted before 2.
- **Watchdog:** `master_busy` stuck at 0 → `resp_valid` with `resp_err`=1 and `resp_data`=0 exactly TIMEOUT_CYC cycles after entering WAIT_BUSY; the next request is served normally.
- **Reset mid-transfer:** `rst` asserted during WAIT_DONE → next cycle all outputs at reset values, `ss_n`=4'b1111, no `resp_valid`.
